pattern_pack_tx: RTL and testbench
==================================

# pattern_pack_tx

Host-side packet serializer: the sending end of the pattern-pack protocol that `diff_freq_serial_out` consumes. It snapshots a 32-bit output pattern, a 32-bit frequency pattern and a control byte, and streams them as PACK_NUM bytes into the UART transmitter's byte interface. It paces the bytes with the UART's tx-done handshake. It sits between a command/test controller and the `UART` tx port (`i_tx_start`, `i_tx_data`, `o_tx_done_tick`).

## Interface
- DATA_BIT, 32: width of each pattern word; must be a multiple of 8.
- PACK_NUM, (DATA_BIT/8)*2+1: bytes per pack (output pattern + freq pattern + control byte).
- GAP_CYCLES, 0: idle clk cycles inserted between a byte's tx-done and the next byte's start.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_start  in  1  single-cycle request to send one pack; sampled only in IDLE.
- i_abort  in  1  synchronous abort of an in-progress pack.
- i_out_pattern  in  DATA_BIT  output pattern word; captured on accepted i_start.
- i_freq_pattern  in  DATA_BIT  frequency pattern word; captured on accepted i_start.
- i_ctrl  in  8  control byte; captured on accepted i_start.
- i_tx_done_tick  in  1  UART tx byte-complete pulse.
- o_tx_start  out  1  one-cycle UART tx start pulse.
- o_tx_data  out  8  byte to transmit; stable from o_tx_start until the matching i_tx_done_tick.
- o_busy  out  1  high from the cycle after start acceptance until return to IDLE.
- o_done_tick  out  1  one-cycle pulse after the last byte completes.

## Operation
- Byte order is fixed. Bytes 0..3 carry i_out_pattern, least-significant byte first. Bytes 4..7 carry i_freq_pattern, LS byte first. Byte PACK_NUM-1 is i_ctrl. For a general DATA_BIT, bytes 0..DATA_BIT/8-1 are the output pattern and the next DATA_BIT/8 bytes are the freq pattern.
- Inputs are copied into a PACK_NUM*8-bit shadow register on acceptance. Input changes after that have no effect on the pack in flight.
- FSM states:
  - IDLE: when i_start=1, capture the inputs, set byte_idx=0, go to SEND.
  - SEND: assert o_tx_start for 1 cycle, drive o_tx_data=byte[byte_idx], go to WAIT.
  - WAIT: on i_tx_done_tick:
    - if byte_idx==PACK_NUM-1, go to DONE;
    - else if GAP_CYCLES>0, byte_idx++ and go to GAP;
    - else byte_idx++ and go to SEND.
  - GAP: count GAP_CYCLES cycles, then go to SEND.
  - DONE: assert o_done_tick for 1 cycle, go to IDLE.
- byte_idx is $clog2(PACK_NUM) bits wide and never exceeds PACK_NUM-1. The gap counter is $clog2(GAP_CYCLES+1) bits wide (minimum 1).
- i_start outside IDLE is ignored; no queueing.
- i_tx_done_tick in IDLE, SEND, GAP or DONE is ignored.
- i_abort in any non-IDLE state forces IDLE on the next edge. No o_done_tick is issued. Abort wins over a simultaneous i_tx_done_tick. i_abort in IDLE together with i_start: abort wins and the start is dropped.
- Asserting rst_n low mid-pack aborts immediately. There is no resume.

## Timing
- Reset values: o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_done_tick=0, state=IDLE, byte_idx=0, shadow=0.
- Accepted i_start at edge N gives o_tx_start=1 and o_busy=1 during cycle N+1.
- After a non-final i_tx_done_tick at edge M, the next o_tx_start occurs in cycle M+1+GAP_CYCLES.
- After the final i_tx_done_tick at edge M, o_done_tick=1 in cycle M+1 and o_busy=0 in cycle M+2.
- A new i_start is accepted at the earliest in the cycle where o_busy is 0.
- All outputs are registered.

## Structure
- Shared package `pattern_pack_pkg` holds:
  - DATA_BIT default;
  - the PACK_NUM formula;
  - byte-order index constants (OUT_BASE=0, FREQ_BASE=DATA_BIT/8, CTRL_IDX=PACK_NUM-1);
  - the FSM state encoding.
- `diff_freq_serial_out` and this block both use the package so the two ends cannot drift.
- No sub-module is required. Byte selection is an indexed part-select of the shadow register.

## Test plan
- Handshake and byte order: reset, then i_start with out=32'h1234_5678, freq=32'hA5A5_0F0F, ctrl=8'h81, model tx_done 5 cycles after each start. Expect o_tx_data sequence 78,56,34,12,0F,0F,A5,A5,81, then one o_done_tick.
- Gap timing: GAP_CYCLES=3. Expect exactly 4 cycles from each non-final tx_done edge to the next o_tx_start. Expect exactly 1 cycle with GAP_CYCLES=0.
- Busy-time inputs: during a pack, pulse i_start and change i_out_pattern to 32'hFFFF_FFFF. Expect the original bytes unchanged and no second pack.
- Abort: assert i_abort together with the tx_done of byte 3. Expect IDLE next cycle, no o_done_tick, o_busy=0. A following i_start restarts from byte 0.
- Async reset: drop rst_n mid-WAIT. Expect all outputs at reset values without waiting for a clk edge. A stray i_tx_done_tick in IDLE produces no output activity.
- End-to-end loopback: pattern_pack_tx feeds `UART` tx, looped to `UART` rx and then to `diff_freq_serial_out`. Expect the received pack to equal the sent pack for 3 random packs.

Source files
------------

// File: rtl/pattern_pack_pkg.sv
// Shared definitions for the pattern-pack protocol (sender and receiver ends).
package pattern_pack_pkg;

  localparam int unsigned DATA_BIT_DEF = 32;

  // Bytes per pack: output pattern + freq pattern + control byte.
  function automatic int unsigned pack_num(input int unsigned data_bit);
    return (data_bit / 8) * 2 + 1;
  endfunction

  // Byte index where the freq pattern starts.
  function automatic int unsigned freq_base(input int unsigned data_bit);
    return data_bit / 8;
  endfunction

  // Byte index of the control byte (always last).
  function automatic int unsigned ctrl_idx(input int unsigned data_bit);
    return pack_num(data_bit) - 1;
  endfunction

  localparam int unsigned PACK_NUM_DEF = pack_num(DATA_BIT_DEF);

  // Byte-order constants for the default pattern width.
  localparam int unsigned OUT_BASE  = 0;
  localparam int unsigned FREQ_BASE = freq_base(DATA_BIT_DEF);
  localparam int unsigned CTRL_IDX  = ctrl_idx(DATA_BIT_DEF);

  // Serializer FSM encoding.
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_SEND = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT = 3'd2;
  localparam logic [ST_W-1:0] ST_GAP  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/pattern_pack_tx.sv
// Host-side pack serializer: snapshots out/freq patterns and a control byte,
// then streams them LS-byte-first into a UART tx byte port, paced by tx-done.
module pattern_pack_tx
  import pattern_pack_pkg::*;
#(
  parameter int unsigned DATA_BIT   = DATA_BIT_DEF,
  parameter int unsigned PACK_NUM   = pack_num(DATA_BIT),
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [DATA_BIT-1:0] i_out_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [7:0]          i_ctrl,
  input  logic                i_tx_done_tick,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  output logic                o_busy,
  output logic                o_done_tick
);

  localparam int unsigned SHADOW_W = PACK_NUM * 8;
  localparam int unsigned IDX_W    = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam int unsigned SEL_W    = IDX_W + 3;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned OUT_LSB  = OUT_BASE * 8;
  localparam int unsigned FREQ_LSB = freq_base(DATA_BIT) * 8;
  localparam int unsigned CTRL_LSB = (PACK_NUM - 1) * 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_NUM - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);

  logic [ST_W-1:0]     state, state_nxt;
  logic [IDX_W-1:0]    byte_idx, idx_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [SHADOW_W-1:0] shadow, shadow_nxt;
  logic [SHADOW_W-1:0] capture_c;
  logic [SEL_W-1:0]    sel_c;

  logic       tx_start_nxt;
  logic [7:0] tx_data_nxt;
  logic       busy_nxt;
  logic       done_nxt;

  // Assemble the pack image from the live inputs (byte 0 in the LSBs).
  always_comb begin
    capture_c = '0;
    capture_c[OUT_LSB  +: DATA_BIT] = i_out_pattern;
    capture_c[FREQ_LSB +: DATA_BIT] = i_freq_pattern;
    capture_c[CTRL_LSB +: 8]        = i_ctrl;
  end

  // Next-state logic; abort from any busy state overrides everything.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = byte_idx;
    gap_nxt    = gap_cnt;
    shadow_nxt = shadow;

    case (state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          state_nxt  = ST_SEND;
          shadow_nxt = capture_c;
          idx_nxt    = '0;
        end
      end
      ST_SEND: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done_tick) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt = byte_idx + IDX_W'(1);
            if (GAP_CYCLES > 0) begin
              state_nxt = ST_GAP;
              gap_nxt   = '0;
            end else begin
              state_nxt = ST_SEND;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_END) begin
          state_nxt = ST_SEND;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (i_abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    sel_c        = SEL_W'({idx_nxt, 3'b000});
    tx_start_nxt = (state_nxt == ST_SEND);
    busy_nxt     = (state_nxt != ST_IDLE);
    done_nxt     = (state_nxt == ST_DONE);
    tx_data_nxt  = o_tx_data;
    if (state_nxt == ST_SEND) begin
      tx_data_nxt = shadow_nxt[sel_c +: 8];
    end
  end

  // State, byte index, gap counter and shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
      gap_cnt  <= '0;
      shadow   <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
      gap_cnt  <= gap_nxt;
      shadow   <= shadow_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tx_start  <= 1'b0;
      o_tx_data   <= 8'h00;
      o_busy      <= 1'b0;
      o_done_tick <= 1'b0;
    end else begin
      o_tx_start  <= tx_start_nxt;
      o_tx_data   <= tx_data_nxt;
      o_busy      <= busy_nxt;
      o_done_tick <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_pack_tx.sv
// Bench for pattern_pack_tx: two instances (no gap, 3-cycle gap), each driven
// by a tx-done responder and checked every cycle against an event-level model.
module tb_pattern_pack_tx;
  import pattern_pack_pkg::*;

  localparam int unsigned DB = DATA_BIT_DEF;
  localparam int PN = int'(PACK_NUM_DEF);
  typedef logic [7:0] pack_a [PN];

  logic clk;
  logic rst_n;
  logic [1:0]         start, abort, done_in, txs, busy, dtick;
  logic [1:0][DB-1:0] outp, freqp;
  logic [1:0][7:0]    ctrl, txd;

  pattern_pack_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
    .i_out_pattern(outp[0]), .i_freq_pattern(freqp[0]), .i_ctrl(ctrl[0]),
    .i_tx_done_tick(done_in[0]), .o_tx_start(txs[0]), .o_tx_data(txd[0]),
    .o_busy(busy[0]), .o_done_tick(dtick[0])
  );

  pattern_pack_tx #(.GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
    .i_out_pattern(outp[1]), .i_freq_pattern(freqp[1]), .i_ctrl(ctrl[1]),
    .i_tx_done_tick(done_in[1]), .o_tx_start(txs[1]), .o_tx_data(txd[1]),
    .o_busy(busy[1]), .o_done_tick(dtick[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err, edge_n;

  // Model: pack in flight, index of current byte, edge after which its start shows.
  bit    m_active [2];
  bit    m_fin    [2];
  int    m_idx    [2];
  int    m_start_at [2];
  pack_a m_bytes  [2];
  bit         e_start [2], e_busy [2], e_done [2], e_chk [2];
  logic [7:0] e_data [2];

  // UART tx-done responder and observation bookkeeping.
  int rcnt [2], rdelay [2], nstarts [2], abort_byte [2], done_edge [2], dcount [2];
  bit gap_pend [2];
  logic [7:0] got [2][$];
  pack_a exp_seq;

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Byte order: out pattern LS first, then freq pattern LS first, then ctrl.
  function automatic pack_a build(input logic [DB-1:0] o, input logic [DB-1:0] f,
                                  input logic [7:0] c);
    pack_a p;
    for (int i = 0; i < PN; i++) begin
      if (i == int'(CTRL_IDX))       p[i] = c;
      else if (i >= int'(FREQ_BASE)) p[i] = 8'(f >> (8 * (i - int'(FREQ_BASE))));
      else                           p[i] = 8'(o >> (8 * (i - int'(OUT_BASE))));
    end
    return p;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] got_v,
                       input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s[dut%0d] t=%0t got=%0h want=%0h", name, k, $time, got_v, exp_v);
    end
  endtask

  // Predict outputs for the cycle following the coming clock edge.
  task automatic model_edge(input int k);
    e_start[k] = 1'b0;
    e_done[k]  = 1'b0;
    if (!rst_n) begin
      m_active[k] = 1'b0;
      m_fin[k]    = 1'b0;
      e_busy[k]   = 1'b0;
      e_chk[k]    = 1'b1;
      e_data[k]   = 8'h00;
    end else begin
      if (m_active[k] && abort[k]) begin
        m_active[k] = 1'b0;
      end else if (m_active[k] && m_fin[k]) begin
        m_active[k] = 1'b0;
      end else if (m_active[k]) begin
        if (done_in[k] && (edge_n > m_start_at[k] + 1)) begin
          if (m_idx[k] == PN - 1) begin
            m_fin[k]  = 1'b1;
            e_done[k] = 1'b1;
          end else begin
            m_idx[k]++;
            m_start_at[k] = edge_n + gap_of(k);
          end
        end
      end else if (start[k] && !abort[k]) begin
        m_bytes[k]    = build(outp[k], freqp[k], ctrl[k]);
        m_active[k]   = 1'b1;
        m_fin[k]      = 1'b0;
        m_idx[k]      = 0;
        m_start_at[k] = edge_n;
      end
      e_start[k] = m_active[k] && !m_fin[k] && (m_start_at[k] == edge_n);
      e_busy[k]  = m_active[k];
      e_chk[k]   = m_active[k] && !m_fin[k] && (edge_n >= m_start_at[k]);
      e_data[k]  = m_bytes[k][m_idx[k]];
    end
  endtask

  // One clock: predict, clock, compare on the falling edge, then drive next inputs.
  task automatic step();
    edge_n++;
    for (int k = 0; k < 2; k++) model_edge(k);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("tx_start", k, 32'(txs[k]), 32'(e_start[k]));
      check("busy", k, 32'(busy[k]), 32'(e_busy[k]));
      check("done_tick", k, 32'(dtick[k]), 32'(e_done[k]));
      if (e_chk[k]) check("tx_data", k, 32'(txd[k]), 32'(e_data[k]));
      if (txs[k] === 1'b1) begin
        got[k].push_back(txd[k]);
        if (gap_pend[k]) begin
          check("gap", k, 32'(edge_n - done_edge[k]), 32'(gap_of(k)));
          gap_pend[k] = 1'b0;
        end
      end
      if (dtick[k] === 1'b1) dcount[k]++;

      start[k]   = 1'b0;
      abort[k]   = 1'b0;
      done_in[k] = 1'b0;
      if (!rst_n) begin
        rcnt[k]     = 0;
        gap_pend[k] = 1'b0;
      end else begin
        if (rcnt[k] > 0) begin
          rcnt[k]--;
          if (rcnt[k] == 0) begin
            done_in[k]   = 1'b1;
            done_edge[k] = edge_n + 1;
            gap_pend[k]  = (nstarts[k] < PN);
            if (abort_byte[k] == nstarts[k] - 1) begin
              abort[k]      = 1'b1;
              abort_byte[k] = -1;
              gap_pend[k]   = 1'b0;
            end
          end
        end
        if (txs[k] === 1'b1) begin
          nstarts[k]++;
          rcnt[k] = (rdelay[k] > 0) ? rdelay[k] : int'($urandom_range(6, 1));
        end
      end
    end
  endtask

  task automatic new_pack(input int k);
    got[k].delete();
    nstarts[k] = 0;
    dcount[k]  = 0;
  endtask

  task automatic run_pack(input int k);
    int n;
    n = 0;
    while (m_active[k] && n < 500) begin
      step();
      n++;
    end
    if (m_active[k]) check("timeout", k, 32'(n), 32'(0));
  endtask

  task automatic check_seq(input int k, input pack_a want);
    check("pack_len", k, 32'(got[k].size()), 32'(PN));
    for (int i = 0; i < PN && i < got[k].size(); i++)
      check($sformatf("byte%0d", i), k, 32'(got[k][i]), 32'(want[i]));
  endtask

  initial begin
    int    n, ab;
    pack_a rb;
    n_vec = 0; n_err = 0; edge_n = 0;
    rst_n = 1'b0;
    start = '0; abort = '0; done_in = '0;
    outp = '0; freqp = '0; ctrl = '0;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_fin[k] = 1'b0; m_idx[k] = 0; m_start_at[k] = 0;
      rcnt[k] = 0; rdelay[k] = 4; nstarts[k] = 0; abort_byte[k] = -1;
      done_edge[k] = 0; dcount[k] = 0; gap_pend[k] = 1'b0;
    end
    exp_seq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h81};

    // Reset state
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      check("rst_tx_start", k, 32'(txs[k]), 32'(0));
      check("rst_tx_data", k, 32'(txd[k]), 32'(0));
      check("rst_busy", k, 32'(busy[k]), 32'(0));
      check("rst_done", k, 32'(dtick[k]), 32'(0));
    end
    rst_n = 1'b1;
    step();

    // Handshake, byte order and gap timing on both instances
    for (int k = 0; k < 2; k++) begin
      outp[k] = 32'h1234_5678; freqp[k] = 32'hA5A5_0F0F; ctrl[k] = 8'h81;
      new_pack(k);
      start[k] = 1'b1;
      step();
      check("lat_start", k, 32'(txs[k]), 32'(1));
      check("lat_busy", k, 32'(busy[k]), 32'(1));
      run_pack(k);
      check_seq(k, exp_seq);
      check("done_cnt", k, 32'(dcount[k]), 32'(1));
      check("idle_busy", k, 32'(busy[k]), 32'(0));
      step();
    end

    // Inputs changing and start pulsing while busy
    new_pack(0);
    start[0] = 1'b1;
    step();
    repeat (6) step();
    outp[0] = 32'hFFFF_FFFF;
    start[0] = 1'b1;
    step();
    run_pack(0);
    check_seq(0, exp_seq);
    check("busy_done_cnt", 0, 32'(dcount[0]), 32'(1));
    repeat (10) step();
    check("no_second", 0, 32'(got[0].size()), 32'(PN));
    outp[0] = 32'h1234_5678;

    // Abort together with tx-done of byte 3, then restart from byte 0
    for (int k = 0; k < 2; k++) begin
      new_pack(k);
      abort_byte[k] = 3;
      start[k] = 1'b1;
      step();
      run_pack(k);
      check("abort_len", k, 32'(got[k].size()), 32'(4));
      check("abort_done", k, 32'(dcount[k]), 32'(0));
      check("abort_busy", k, 32'(busy[k]), 32'(0));
      step();
      new_pack(k);
      start[k] = 1'b1;
      step();
      run_pack(k);
      check_seq(k, exp_seq);
      check("restart_done", k, 32'(dcount[k]), 32'(1));
    end

    // Abort with start in IDLE drops the start
    start[0] = 1'b1;
    abort[0] = 1'b1;
    step();
    check("drop_start", 0, 32'(txs[0]), 32'(0));
    check("drop_busy", 0, 32'(busy[0]), 32'(0));

    // Asynchronous reset in the middle of WAIT
    new_pack(1);
    start[1] = 1'b1;
    step();
    n = 0;
    while (!(nstarts[1] == 2 && rcnt[1] == 2) && n < 100) begin
      step();
      n++;
    end
    check("reach_wait", 1, 32'(n < 100), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_tx_start", k, 32'(txs[k]), 32'(0));
      check("arst_tx_data", k, 32'(txd[k]), 32'(0));
      check("arst_busy", k, 32'(busy[k]), 32'(0));
      check("arst_done", k, 32'(dtick[k]), 32'(0));
    end
    repeat (2) step();
    rst_n = 1'b1;
    new_pack(0);
    new_pack(1);
    step();

    // Stray tx-done in IDLE
    done_in = 2'b11;
    step();
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      check("stray_starts", k, 32'(got[k].size()), 32'(0));
      check("stray_done", k, 32'(dcount[k]), 32'(0));
    end

    // Randomized packs with random tx latency, noise and occasional aborts
    rdelay[0] = 0;
    rdelay[1] = 0;
    for (int it = 0; it < 24; it++) begin
      int k;
      k = it % 2;
      new_pack(k);
      ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(PN - 1, 0)) : -1;
      abort_byte[k] = ab;
      outp[k]  = $urandom;
      freqp[k] = $urandom;
      ctrl[k]  = 8'($urandom);
      rb = build(outp[k], freqp[k], ctrl[k]);
      start[k] = 1'b1;
      n = 0;
      do begin
        step();
        n++;
        if (m_active[k]) begin
          if ($urandom_range(7, 0) == 0) start[k] = 1'b1;
          if ($urandom_range(3, 0) == 0) outp[k] = $urandom;
          if ($urandom_range(3, 0) == 0) freqp[k] = $urandom;
          if ($urandom_range(3, 0) == 0) ctrl[k] = 8'($urandom);
        end
      end while (m_active[k] && n < 500);
      if (m_active[k]) check("rand_timeout", k, 32'(n), 32'(0));
      if (ab < 0) begin
        check_seq(k, rb);
        check("rand_done", k, 32'(dcount[k]), 32'(1));
      end else begin
        check("rand_abort_len", k, 32'(got[k].size()), 32'(ab + 1));
        check("rand_abort_done", k, 32'(dcount[k]), 32'(0));
      end
      repeat ($urandom_range(2, 1)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
